// File: rtl/ej4.sv
// ej4 -- registered evaluation of three fixed 4-input Boolean functions.
//
// Every rising clk edge samples the minterm index {A,B,C,D} and loads:
//   f/fb : F = B XNOR D            (minterms 0,2,5,7,8,10,13,15) and complement
//   g/gb : G = AB + BC + CD        (minterms 3,6,7,11,12,13,14,15) and complement
//   h/hb : H = A ^ B ^ C ^ D       (minterms 1,2,4,7,8,11,13,14) and complement
// A synchronous active-high reset forces f,g,h to 0 and fb,gb,hb to 1.
// Latency is one cycle, and every output comes straight from a flip-flop.
//
// Ports:
//   clk        in   single clock, rising edge
//   reset      in   synchronous, active-high
//   A,B,C,D    in   function variables, A is the MSB of the minterm index
//   f,g,h      out  registered F,G,H
//   fb,gb,hb   out  registered complements of F,G,H
module ej4 (
  input  logic clk,
  input  logic reset,
  input  logic A,
  input  logic B,
  input  logic C,
  input  logic D,
  output logic f,
  output logic g,
  output logic h,
  output logic fb,
  output logic gb,
  output logic hb
);

  logic f_q, g_q, h_q;
  logic fb_q, gb_q, hb_q;
  logic f_d, g_d, h_d;

  always_comb begin
    f_d = ~(B ^ D);
    g_d = (A & B) | (B & C) | (C & D);
    h_d = A ^ B ^ C ^ D;
  end

  // The complement flops have their own registers, which are loaded with the
  // inverted next-state values. This keeps the complement invariant exact on
  // every edge, including the reset edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      f_q  <= 1'b0;
      g_q  <= 1'b0;
      h_q  <= 1'b0;
      fb_q <= 1'b1;
      gb_q <= 1'b1;
      hb_q <= 1'b1;
    end else begin
      f_q  <= f_d;
      g_q  <= g_d;
      h_q  <= h_d;
      fb_q <= ~f_d;
      gb_q <= ~g_d;
      hb_q <= ~h_d;
    end
  end

  assign f  = f_q;
  assign g  = g_q;
  assign h  = h_q;
  assign fb = fb_q;
  assign gb = gb_q;
  assign hb = hb_q;

endmodule

// File: tb/tb_ej4.sv
module tb_ej4;

  logic clk;
  logic reset;
  logic A, B, C, D;
  logic f, g, h, fb, gb, hb;

  int checks;
  int errors;

  ej4 dut (
    .clk  (clk),
    .reset(reset),
    .A    (A),
    .B    (B),
    .C    (C),
    .D    (D),
    .f    (f),
    .g    (g),
    .h    (h),
    .fb   (fb),
    .gb   (gb),
    .hb   (hb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: each function is given as its minterm list, written as
  // a 16-bit truth-table mask that is indexed by {A,B,C,D}.
  function automatic logic [5:0] model(input logic rst, input logic [3:0] idx);
    logic [15:0] fm, gm, hm;
    logic ef, eg, eh;
    fm = 16'hA5A5;  // 0,2,5,7,8,10,13,15
    gm = 16'hF8C8;  // 3,6,7,11,12,13,14,15
    hm = 16'h6996;  // 1,2,4,7,8,11,13,14
    if (rst) return 6'b000_111;
    ef = fm[idx];
    eg = gm[idx];
    eh = hm[idx];
    return {ef, eg, eh, ~ef, ~eg, ~eh};
  endfunction

  function automatic logic [5:0] outs();
    return {f, g, h, fb, gb, hb};
  endfunction

  task automatic drive(input logic rst, input logic [3:0] idx);
    reset = rst;
    {A, B, C, D} = idx;
  endtask

  task automatic test_reset();
    logic [5:0] exp;
    drive(1'b1, 4'b1111);
    @(posedge clk); #1;
    exp = 6'b000_111;
    checks++;
    if (outs() !== exp) begin
      errors++;
      $display("FAIL reset_1111 got %b expected %b", outs(), exp);
    end
  endtask

  task automatic test_zero();
    logic [5:0] exp;
    drive(1'b0, 4'b0000);
    @(posedge clk); #1;
    exp = 6'b100_011;
    checks++;
    if (outs() !== exp) begin
      errors++;
      $display("FAIL abcd_0000 got %b expected %b", outs(), exp);
    end
  endtask

  task automatic test_sequence();
    logic [3:0] idx [3];
    logic [5:0] exp [3];
    idx[0] = 4'b0111; exp[0] = 6'b111_000;
    idx[1] = 4'b1100; exp[1] = 6'b010_101;
    idx[2] = 4'b0001; exp[2] = 6'b001_110;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, idx[i]);
      @(posedge clk); #1;
      checks++;
      if (outs() !== exp[i]) begin
        errors++;
        $display("FAIL seq_%b got %b expected %b", idx[i], outs(), exp[i]);
      end
    end
  endtask

  // Sweeps all 16 indices. The reset is asserted on the edge at index rst_at
  // (use 16 for no reset); the following edges must show function values again.
  task automatic test_sweep(input int rst_at);
    logic [5:0] exp;
    logic r;
    for (int i = 0; i < 16; i++) begin
      r = (i == rst_at);
      drive(r, 4'(i));
      @(posedge clk); #1;
      exp = model(r, 4'(i));
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL sweep_%0d rst=%0b got %b expected %b", i, r, outs(), exp);
      end
      checks++;
      if ({fb, gb, hb} !== ~{f, g, h}) begin
        errors++;
        $display("FAIL complement_%0d got fgh=%b fgh_b=%b", i, {f, g, h}, {fb, gb, hb});
      end
    end
  endtask

  task automatic test_mid_cycle();
    logic [5:0] exp;
    drive(1'b0, 4'b0000);
    @(posedge clk); #1;
    exp = 6'b100_011;
    #2 {A, B, C, D} = 4'b0001;
    #1;
    checks++;
    if (outs() !== exp) begin
      errors++;
      $display("FAIL midcycle_hold got %b expected %b", outs(), exp);
    end
    #2 {A, B, C, D} = 4'b0000;
    #1;
    checks++;
    if (outs() !== exp) begin
      errors++;
      $display("FAIL midcycle_back got %b expected %b", outs(), exp);
    end
    @(posedge clk); #1;
    checks++;
    if (outs() !== exp) begin
      errors++;
      $display("FAIL midcycle_edge got %b expected %b", outs(), exp);
    end
  endtask

  task automatic test_random();
    logic [5:0] exp;
    logic [3:0] idx;
    logic r;
    for (int i = 0; i < 200; i++) begin
      idx = 4'($urandom_range(0, 15));
      r = ($urandom_range(0, 9) == 0);
      drive(r, idx);
      @(posedge clk); #1;
      exp = model(r, idx);
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL random_%0d idx=%b rst=%0b got %b expected %b", i, idx, r, outs(), exp);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    drive(1'b1, 4'b0000);
    test_reset();
    test_zero();
    test_sequence();
    test_sweep(16);
    test_mid_cycle();
    test_sweep(7);
    test_reset();
    test_sweep(0);
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
